// File: rtl/boot_memory_pkg.sv
// Shared constants, state type and sizing helper for the boot memory block.
package boot_memory_pkg;

    localparam int MEMORY_ADDRESS_BITS = 8;
    localparam int MEMORY_DATA_BITS    = 8;
    localparam int BOOT_MEMORY_DEPTH   = 256;

    typedef enum logic {
        BOOT,
        RUN
    } boot_state_t;

    // Index width needed to address DEPTH array entries (at least one bit).
    function automatic int index_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/boot_memory_loader.sv
// Byte-stream boot loader: fills the array from address 0 while holding the CPU,
// then moves to RUN for good (until the next reset).
module boot_memory_loader
    import boot_memory_pkg::*;
#(
    parameter int ADDR_BITS   = MEMORY_ADDRESS_BITS,
    parameter int DATA_BITS   = MEMORY_DATA_BITS,
    parameter int DEPTH       = BOOT_MEMORY_DEPTH,
    parameter bit BOOT_ENABLE = 1'b1,
    parameter int IDX_BITS    = index_bits(DEPTH)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_boot_valid,
    input  logic [DATA_BITS-1:0] i_boot_data,
    input  logic                 i_boot_last,
    output logic                 o_boot_ready,
    output logic                 o_cpu_hold,
    output logic                 o_boot_done,
    output logic                 o_wr_en,
    output logic [IDX_BITS-1:0]  o_wr_idx,
    output logic [DATA_BITS-1:0] o_wr_data
);

    localparam boot_state_t          RESET_STATE = BOOT_ENABLE ? BOOT : RUN;
    localparam logic [ADDR_BITS-1:0] LAST_PTR    = ADDR_BITS'(DEPTH - 1);

    boot_state_t          r_state;
    boot_state_t          w_next_state;
    logic [ADDR_BITS-1:0] r_ptr;
    logic [ADDR_BITS-1:0] w_next_ptr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= RESET_STATE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_next_state;
            r_ptr   <= w_next_ptr;
        end
    end

    // Leave BOOT on the edge that stores the flagged last byte or fills the array.
    always_comb begin
        w_next_state = r_state;
        w_next_ptr   = r_ptr;
        if (r_state == BOOT && i_boot_valid) begin
            w_next_ptr = r_ptr + ADDR_BITS'(1);
            if (i_boot_last || r_ptr == LAST_PTR) begin
                w_next_state = RUN;
            end
        end
    end

    always_comb begin
        o_boot_ready = (r_state == BOOT);
        o_cpu_hold   = (r_state == BOOT);
        o_boot_done  = (r_state == RUN);
        o_wr_en      = (r_state == BOOT) && i_boot_valid;
        o_wr_idx     = r_ptr[IDX_BITS-1:0];
        o_wr_data    = i_boot_data;
    end

endmodule

// File: rtl/boot_memory.sv
// Unified program/data memory for the execution unit's RAM bus, preloaded by the
// boot loader; owns the array, its shared write port, the tristate and bus_error.
module boot_memory
    import boot_memory_pkg::*;
#(
    parameter int ADDR_BITS   = MEMORY_ADDRESS_BITS,
    parameter int DATA_BITS   = MEMORY_DATA_BITS,
    parameter int DEPTH       = BOOT_MEMORY_DEPTH,
    parameter bit BOOT_ENABLE = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [ADDR_BITS-1:0] i_ram_address,
    inout  wire  [DATA_BITS-1:0] io_ram_data,
    input  logic                 i_ram_read_en,
    input  logic                 i_ram_write_en,
    input  logic                 i_boot_valid,
    input  logic [DATA_BITS-1:0] i_boot_data,
    input  logic                 i_boot_last,
    output logic                 o_boot_ready,
    output logic                 o_cpu_hold,
    output logic                 o_boot_done,
    output logic                 o_bus_error
);

    localparam int IDX_BITS = index_bits(DEPTH);

    logic [DATA_BITS-1:0] r_mem [DEPTH];
    logic                 r_bus_error;

    logic                 w_boot_we;
    logic [IDX_BITS-1:0]  w_boot_idx;
    logic [DATA_BITS-1:0] w_boot_wdata;
    logic [IDX_BITS-1:0]  w_cpu_idx;
    logic                 w_in_range;
    logic                 w_run;
    logic                 w_cpu_we;
    logic                 w_mem_we;
    logic [IDX_BITS-1:0]  w_mem_idx;
    logic [DATA_BITS-1:0] w_mem_wdata;
    logic                 w_drive_en;
    logic [DATA_BITS-1:0] w_read_data;
    logic                 w_bus_fault;

    boot_memory_loader #(
        .ADDR_BITS   (ADDR_BITS),
        .DATA_BITS   (DATA_BITS),
        .DEPTH       (DEPTH),
        .BOOT_ENABLE (BOOT_ENABLE),
        .IDX_BITS    (IDX_BITS)
    ) u_loader (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_boot_valid (i_boot_valid),
        .i_boot_data  (i_boot_data),
        .i_boot_last  (i_boot_last),
        .o_boot_ready (o_boot_ready),
        .o_cpu_hold   (o_cpu_hold),
        .o_boot_done  (o_boot_done),
        .o_wr_en      (w_boot_we),
        .o_wr_idx     (w_boot_idx),
        .o_wr_data    (w_boot_wdata)
    );

    assign w_run      = o_boot_done;
    assign w_cpu_idx  = i_ram_address[IDX_BITS-1:0];
    assign w_in_range = 32'(i_ram_address) < DEPTH;

    // Loader and CPU never write in the same state, so the mux needs no arbitration.
    assign w_cpu_we    = w_run && i_ram_write_en && w_in_range;
    assign w_mem_we    = w_boot_we || w_cpu_we;
    assign w_mem_idx   = w_boot_we ? w_boot_idx : w_cpu_idx;
    assign w_mem_wdata = w_boot_we ? w_boot_wdata : io_ram_data;

    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_idx] <= w_mem_wdata;
        end
    end

    assign w_drive_en  = w_run && i_ram_read_en && !i_ram_write_en;
    assign w_read_data = w_in_range ? r_mem[w_cpu_idx] : '0;
    assign io_ram_data = w_drive_en ? w_read_data : 'z;

    assign w_bus_fault = w_run && ((i_ram_read_en && i_ram_write_en)
                                || ((i_ram_read_en || i_ram_write_en) && !w_in_range));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bus_error <= 1'b0;
        end else if (w_bus_fault) begin
            r_bus_error <= 1'b1;
        end
    end

    assign o_bus_error = r_bus_error;

endmodule

// File: tb/tb_boot_memory.sv
// Directed self-checking bench for boot_memory: default build, DEPTH=16 build
// and BOOT_ENABLE=0 build share one clock and reset.
module tb_boot_memory;

    logic clk;
    logic rstN;

    logic [7:0] mainAddr;
    logic       mainRead;
    logic       mainWrite;
    logic       mainDrive;
    logic [7:0] mainDriveData;
    wire  [7:0] mainRam;
    logic       mainBootValid;
    logic [7:0] mainBootData;
    logic       mainBootLast;
    logic       mainReady;
    logic       mainHold;
    logic       mainDone;
    logic       mainError;

    logic [7:0] smallAddr;
    logic       smallRead;
    logic       smallWrite;
    logic       smallDrive;
    logic [7:0] smallDriveData;
    wire  [7:0] smallRam;
    logic       smallBootValid;
    logic [7:0] smallBootData;
    logic       smallBootLast;
    logic       smallReady;
    logic       smallHold;
    logic       smallDone;
    logic       smallError;

    logic       nbDrive;
    wire  [7:0] nbRam;
    logic       nbReady;
    logic       nbHold;
    logic       nbDone;
    logic       nbError;

    int compareCount  = 0;
    int mismatchCount = 0;

    assign mainRam  = mainDrive  ? mainDriveData  : 'z;
    assign smallRam = smallDrive ? smallDriveData : 'z;
    assign nbRam    = nbDrive    ? 8'h00          : 'z;

    boot_memory dutMain (
        .i_clk          (clk),
        .i_rst_n        (rstN),
        .i_ram_address  (mainAddr),
        .io_ram_data    (mainRam),
        .i_ram_read_en  (mainRead),
        .i_ram_write_en (mainWrite),
        .i_boot_valid   (mainBootValid),
        .i_boot_data    (mainBootData),
        .i_boot_last    (mainBootLast),
        .o_boot_ready   (mainReady),
        .o_cpu_hold     (mainHold),
        .o_boot_done    (mainDone),
        .o_bus_error    (mainError)
    );

    boot_memory #(.DEPTH(16)) dutSmall (
        .i_clk          (clk),
        .i_rst_n        (rstN),
        .i_ram_address  (smallAddr),
        .io_ram_data    (smallRam),
        .i_ram_read_en  (smallRead),
        .i_ram_write_en (smallWrite),
        .i_boot_valid   (smallBootValid),
        .i_boot_data    (smallBootData),
        .i_boot_last    (smallBootLast),
        .o_boot_ready   (smallReady),
        .o_cpu_hold     (smallHold),
        .o_boot_done    (smallDone),
        .o_bus_error    (smallError)
    );

    boot_memory #(.BOOT_ENABLE(1'b0)) dutNoBoot (
        .i_clk          (clk),
        .i_rst_n        (rstN),
        .i_ram_address  (8'h00),
        .io_ram_data    (nbRam),
        .i_ram_read_en  (1'b0),
        .i_ram_write_en (1'b0),
        .i_boot_valid   (1'b0),
        .i_boot_data    (8'h00),
        .i_boot_last    (1'b0),
        .o_boot_ready   (nbReady),
        .o_cpu_hold     (nbHold),
        .o_boot_done    (nbDone),
        .o_bus_error    (nbError)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %02h, expected %02h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [7:0] addr, input logic [7:0] data);
        mainRead      = rd;
        mainWrite     = wr;
        mainAddr      = addr;
        mainDriveData = data;
        mainDrive     = wr;
    endtask

    task automatic applySmall(input logic rd, input logic wr, input logic [7:0] addr, input logic [7:0] data);
        smallRead      = rd;
        smallWrite     = wr;
        smallAddr      = addr;
        smallDriveData = data;
        smallDrive     = wr;
    endtask

    task automatic bootMain(input logic [7:0] data, input logic last);
        mainBootValid = 1'b1;
        mainBootData  = data;
        mainBootLast  = last;
        tick();
        mainBootValid = 1'b0;
        mainBootLast  = 1'b0;
    endtask

    task automatic bootSmall(input logic [7:0] data);
        smallBootValid = 1'b1;
        smallBootData  = data;
        tick();
        smallBootValid = 1'b0;
    endtask

    initial begin
        rstN           = 1'b0;
        nbDrive        = 1'b0;
        mainBootValid  = 1'b0;
        mainBootData   = 8'h00;
        mainBootLast   = 1'b0;
        smallBootValid = 1'b0;
        smallBootData  = 8'h00;
        smallBootLast  = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        applySmall(1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        tick();

        checkOutput("rst_ready", 8'(mainReady), 8'h01);
        checkOutput("rst_hold", 8'(mainHold), 8'h01);
        checkOutput("rst_done", 8'(mainDone), 8'h00);
        checkOutput("rst_error", 8'(mainError), 8'h00);
        checkOutput("rst_drive", 8'(dutMain.w_drive_en), 8'h00);
        checkOutput("small_rst_hold", 8'(smallHold), 8'h01);
        checkOutput("nb_rst_ready", 8'(nbReady), 8'h00);
        checkOutput("nb_rst_hold", 8'(nbHold), 8'h00);
        checkOutput("nb_rst_done", 8'(nbDone), 8'h01);
        rstN = 1'b1;

        bootMain(8'h15, 1'b0);
        checkOutput("boot0_hold", 8'(mainHold), 8'h01);
        applyStimulus(1'b1, 1'b1, 8'h30, 8'h77);
        #1 checkOutput("boot_bus_drive", 8'(dutMain.w_drive_en), 8'h00);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        bootMain(8'h2A, 1'b0);
        checkOutput("boot1_hold", 8'(mainHold), 8'h01);
        checkOutput("boot1_done", 8'(mainDone), 8'h00);
        bootMain(8'h3C, 1'b1);
        checkOutput("boot2_done", 8'(mainDone), 8'h01);
        checkOutput("boot2_hold", 8'(mainHold), 8'h00);
        checkOutput("boot2_ready", 8'(mainReady), 8'h00);
        checkOutput("boot2_error", 8'(mainError), 8'h00);

        applyStimulus(1'b1, 1'b0, 8'h00, 8'h00);
        #1 checkOutput("rd_00", mainRam, 8'h15);
        applyStimulus(1'b1, 1'b0, 8'h01, 8'h00);
        #1 checkOutput("rd_01", mainRam, 8'h2A);
        checkOutput("rd_01_drive", 8'(dutMain.w_drive_en), 8'h01);
        applyStimulus(1'b1, 1'b0, 8'h02, 8'h00);
        #1 checkOutput("rd_02", mainRam, 8'h3C);
        applyStimulus(1'b0, 1'b0, 8'h01, 8'h00);
        #1 checkOutput("idle_drive", 8'(dutMain.w_drive_en), 8'h00);
        tick();

        applyStimulus(1'b0, 1'b1, 8'h10, 8'hC3);
        #1 checkOutput("wr_drive", 8'(dutMain.w_drive_en), 8'h00);
        tick();
        applyStimulus(1'b1, 1'b0, 8'h10, 8'h00);
        #1 checkOutput("rd_10", mainRam, 8'hC3);
        checkOutput("wr_error", 8'(mainError), 8'h00);
        applyStimulus(1'b0, 1'b1, 8'hC0, 8'h9D);
        tick();

        applyStimulus(1'b1, 1'b1, 8'h20, 8'h5A);
        #1 checkOutput("rw_drive", 8'(dutMain.w_drive_en), 8'h00);
        checkOutput("rw_error_pre", 8'(mainError), 8'h00);
        tick();
        checkOutput("rw_error", 8'(mainError), 8'h01);
        applyStimulus(1'b1, 1'b0, 8'h20, 8'h00);
        #1 checkOutput("rd_20", mainRam, 8'h5A);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        checkOutput("error_sticky", 8'(mainError), 8'h01);

        rstN = 1'b0;
        #2;
        checkOutput("rst2_error", 8'(mainError), 8'h00);
        checkOutput("rst2_ready", 8'(mainReady), 8'h01);
        checkOutput("rst2_done", 8'(mainDone), 8'h00);
        rstN = 1'b1;

        // CPU traffic during boot must be ignored: no write, no drive, no error.
        applyStimulus(1'b1, 1'b1, 8'hC0, 8'h77);
        for (int i = 0; i < 50; i++) begin
            if (i % 7 == 3) tick();
            bootMain(8'(8'h40 + i), 1'b0);
            checkOutput("aborted_hold", 8'(mainHold), 8'h01);
        end
        checkOutput("aborted_drive", 8'(dutMain.w_drive_en), 8'h00);
        rstN = 1'b0;
        #2;
        checkOutput("mid_rst_ready", 8'(mainReady), 8'h01);
        checkOutput("mid_rst_hold", 8'(mainHold), 8'h01);
        rstN = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (i % 9 == 4) tick();
            bootMain(8'(8'h80 + i), i == 99);
            if (i < 99) checkOutput("reboot_hold", 8'(mainHold), 8'h01);
        end
        checkOutput("reboot_done", 8'(mainDone), 8'h01);
        checkOutput("reboot_hold_end", 8'(mainHold), 8'h00);
        checkOutput("reboot_error", 8'(mainError), 8'h00);
        applyStimulus(1'b1, 1'b0, 8'hC0, 8'h00);
        #1 checkOutput("rd_c0_kept", mainRam, 8'h9D);
        applyStimulus(1'b1, 1'b0, 8'h00, 8'h00);
        #1 checkOutput("rd_00_new", mainRam, 8'h80);
        applyStimulus(1'b1, 1'b0, 8'h31, 8'h00);
        #1 checkOutput("rd_31_new", mainRam, 8'hB1);
        applyStimulus(1'b1, 1'b0, 8'h63, 8'h00);
        #1 checkOutput("rd_63_new", mainRam, 8'hE3);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);

        for (int i = 0; i < 16; i++) begin
            bootSmall(8'(8'h60 + i));
            if (i == 14) checkOutput("small_hold_14", 8'(smallHold), 8'h01);
        end
        checkOutput("small_done", 8'(smallDone), 8'h01);
        checkOutput("small_hold", 8'(smallHold), 8'h00);
        applySmall(1'b1, 1'b0, 8'h0F, 8'h00);
        #1 checkOutput("small_rd_0f", smallRam, 8'h6F);
        tick();
        checkOutput("small_error_clean", 8'(smallError), 8'h00);
        applySmall(1'b1, 1'b0, 8'h20, 8'h00);
        #1 checkOutput("small_rd_20", smallRam, 8'h00);
        checkOutput("small_rd_20_drive", 8'(dutSmall.w_drive_en), 8'h01);
        tick();
        checkOutput("small_error_range", 8'(smallError), 8'h01);
        applySmall(1'b0, 1'b1, 8'h1F, 8'h11);
        tick();
        applySmall(1'b1, 1'b0, 8'h0F, 8'h00);
        #1 checkOutput("small_oor_wr_dropped", smallRam, 8'h6F);
        applySmall(1'b0, 1'b0, 8'h00, 8'h00);

        checkOutput("nb_done", 8'(nbDone), 8'h01);
        checkOutput("nb_hold", 8'(nbHold), 8'h00);
        checkOutput("nb_error", 8'(nbError), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/boot_memory.md
Name: boot_memory

Overview:
- Memory-side responder for the execution unit's RAM bus (address, bidirectional data, read enable, write enable).
- Holds program and data in one array.
- After reset, a byte-stream boot loader fills the array while the CPU is held. The block then releases the CPU and serves its fetch, load and store cycles.
- Sits beside exec_unit at the top level and replaces the plain memory model.

Parameters:
- ADDR_BITS, 8, width of ram_address and of the boot write pointer.
- DATA_BITS, 8, width of ram_data and boot_data.
- DEPTH, 256, number of implemented locations; must satisfy 1 <= DEPTH <= 2**ADDR_BITS.
- BOOT_ENABLE, 1, 1 = start in BOOT after reset; 0 = start directly in RUN.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- ram_address  in  ADDR_BITS  CPU address; registered by the initiator.
- ram_data  inout  DATA_BITS  CPU data; driven by this block only during read service, otherwise high-Z.
- ram_read_en  in  1  CPU read request.
- ram_write_en  in  1  CPU write strobe; data is sampled from ram_data.
- boot_valid  in  1  boot byte present.
- boot_data  in  DATA_BITS  boot byte.
- boot_last  in  1  qualifies the final boot byte.
- boot_ready  out  1  loader accepts a byte this cycle.
- cpu_hold  out  1  keeps the execution unit in reset/IDLE.
- boot_done  out  1  loading finished.
- bus_error  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - state = BOOT if BOOT_ENABLE, else RUN; boot pointer = 0.
  - boot_ready = BOOT_ENABLE; cpu_hold = BOOT_ENABLE; boot_done = !BOOT_ENABLE; bus_error = 0; ram_data released to Z.
  - The memory array is not cleared.
- Reset mid-boot: the pointer returns to 0 and loading restarts. Bytes already written stay in the array until they are overwritten.
- State BOOT:
  - boot_ready = 1; cpu_hold = 1.
  - On a clock edge with boot_valid=1: mem[ptr] <= boot_data; ptr <= ptr+1. Throughput is one byte per cycle.
  - The transition to RUN happens on the same edge if boot_last=1 or ptr == DEPTH-1.
  - boot_valid=0 leaves ptr and mem unchanged.
  - The CPU bus is ignored: no reads are served, writes are dropped, ram_data = Z, and bus_error is not touched.
- State RUN:
  - boot_ready = 0; cpu_hold = 0; boot_done = 1.
  - RUN is terminal until the next reset. Boot inputs are ignored.
- Read, RUN only, zero-wait:
  - While ram_read_en=1 and ram_write_en=0, ram_data = mem[ram_address], combinational from the registered address.
  - The initiator samples the data at the next rising edge, so its two-cycle fetch (MSB at pc, LSB at pc+1) and its load stage see valid data.
- Write, RUN only:
  - On a rising edge with ram_write_en=1: mem[ram_address] <= ram_data.
  - ram_data is never driven by this block while ram_write_en=1.
- Simultaneous read and write enables: the write is performed, ram_data stays Z, and bus_error is set.
- Out-of-range address (ram_address >= DEPTH, possible only when DEPTH < 2**ADDR_BITS):
  - A read drives all zeros.
  - A write is dropped.
  - Either one sets bus_error.
- bus_error clears only on reset.
- A write and a read to the same address in consecutive cycles return the new value (write-through array, no read buffering).

Decomposition:
- constants_pkg: add BOOT_MEMORY_DEPTH; reuse MEMORY_ADDRESS_BITS and MEMORY_DATA_BITS as the defaults for ADDR_BITS and DATA_BITS.
- Shared package typedef: boot_state_t enum {BOOT, RUN}.
- One sub-module, boot_loader: FSM, pointer, and the boot_ready/cpu_hold/boot_done outputs. It supplies the write port address, data and enable to the array in boot_memory.
- The top level muxes the array write port between the loader and the CPU, and holds the tristate, range check and error logic.

Test Plan:
- Boot three bytes 8'h15, 8'h2A, 8'h3C with boot_last on the third -> mem[0..2] = 15, 2A, 3C; boot_done=1 and cpu_hold=0 one edge after the third byte; boot_ready=0.
- In RUN, address=8'h01 with read_en=1 -> ram_data = 2A in the same cycle; read_en=0 -> ram_data = Z.
- In RUN, drive 8'hC3 on ram_data with write_en=1 at address 8'h10 for one edge, then read 8'h10 -> C3; bus_error stays 0.
- read_en=1 and write_en=1 together at 8'h20 with data 8'h5A -> mem[20]=5A, ram_data not driven by the block, bus_error=1 and remains 1 through later clean cycles until reset.
- Boot 100 bytes with boot_valid gaps, then pulse reset low at byte 50 -> boot_ready=1, ptr restarts at 0, the new stream overwrites from address 0, cpu_hold stays 1 throughout.
- DEPTH=16 build: boot 16 bytes with no boot_last -> RUN entered after byte 15; a CPU read at 8'h20 -> 8'h00 and bus_error=1; BOOT_ENABLE=0 build -> cpu_hold=0 and boot_done=1 straight out of reset.
